// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic core of a 4-tap FIR filter.
// Each accepted sample takes DW cycles of LSB-first LUT accumulation, then emits one y_valid pulse.
module da_fir_engine #(
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int C0 = 3,
    parameter int C1 = -5,
    parameter int C2 = 7,
    parameter int C3 = 2,
    localparam int OW = DW + CW + 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 reset_DA,
    input  logic                 start_DA,
    input  logic [DW-1:0]        sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic signed [OW-1:0] y_out,
    output logic                 y_valid
);

    localparam int LW = CW + 2;
    localparam int KW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic signed [LW-1:0] K0 = LW'(C0);
    localparam logic signed [LW-1:0] K1 = LW'(C1);
    localparam logic signed [LW-1:0] K2 = LW'(C2);
    localparam logic signed [LW-1:0] K3 = LW'(C3);

    typedef enum logic {IDLE, CALC} state_t;

    state_t                state;
    logic [DW-1:0]         tap0, tap1, tap2, tap3;
    logic signed [OW-1:0]  acc;
    logic [KW-1:0]         k;
    logic [3:0]            addr;
    logic signed [LW-1:0]  lut;
    logic signed [OW-1:0]  term;

    assign addr = {tap3[k], tap2[k], tap1[k], tap0[k]};

    // Coefficient-sum LUT: two guard bits keep the sum of four coefficients from wrapping.
    always_comb begin
        lut = '0;
        if (addr[0]) lut = lut + K0;
        if (addr[1]) lut = lut + K1;
        if (addr[2]) lut = lut + K2;
        if (addr[3]) lut = lut + K3;
    end

    assign term         = OW'(lut) <<< k;
    assign sample_ready = (state == IDLE) && start_DA && !reset_DA;

    always_ff @(posedge clk) begin
        if (!resetn || reset_DA) begin
            state   <= IDLE;
            tap0    <= '0;
            tap1    <= '0;
            tap2    <= '0;
            tap3    <= '0;
            acc     <= '0;
            k       <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid && sample_ready) begin
                        tap0  <= sample_in;
                        tap1  <= tap0;
                        tap2  <= tap1;
                        tap3  <= tap2;
                        acc   <= '0;
                        k     <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // The MSB of a two's-complement sample carries negative weight.
                    if (k == KW'(DW - 1)) begin
                        y_out   <= acc - term;
                        y_valid <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        acc <= acc + term;
                        k   <= k + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_da_fir_engine.sv
// Bench for da_fir_engine: a default-coefficient instance and a -128 coefficient instance,
// checked every cycle against an arithmetic FIR model plus hand-computed literal results.
module tb_da_fir_engine;

    localparam int DW = 8;
    localparam int OW = 18;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 reset_da     [2];
    logic                 start_da     [2];
    logic signed [DW-1:0] sample_in    [2];
    logic                 sample_valid [2];
    logic                 sample_ready [2];
    logic signed [OW-1:0] y_out        [2];
    logic                 y_valid      [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit checking = 1'b0;

    int coef [2][4] = '{'{3, -5, 7, 2}, '{-128, -128, -128, -128}};
    int hist [2][4];
    int rem  [2];
    int pend [2];
    int y_exp [2];
    bit yv_exp [2];

    int res0 [$];
    int res1 [$];
    int stamp0 [$];

    always #5 clk = ~clk;

    da_fir_engine dut (
        .clk(clk), .resetn(resetn), .reset_DA(reset_da[0]), .start_DA(start_da[0]),
        .sample_in(sample_in[0]), .sample_valid(sample_valid[0]),
        .sample_ready(sample_ready[0]), .y_out(y_out[0]), .y_valid(y_valid[0])
    );

    da_fir_engine #(.C0(-128), .C1(-128), .C2(-128), .C3(-128)) dut_x (
        .clk(clk), .resetn(resetn), .reset_DA(reset_da[1]), .start_DA(start_da[1]),
        .sample_in(sample_in[1]), .sample_valid(sample_valid[1]),
        .sample_ready(sample_ready[1]), .y_out(y_out[1]), .y_valid(y_valid[1])
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted sample yields the plain FIR sum DW edges later; busy in between.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!resetn || reset_da[i]) begin
                rem[i]    <= 0;
                y_exp[i]  <= 0;
                yv_exp[i] <= 1'b0;
                for (int j = 0; j < 4; j++) hist[i][j] <= 0;
            end else begin
                yv_exp[i] <= 1'b0;
                if (rem[i] > 0) begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) begin
                        y_exp[i]  <= pend[i];
                        yv_exp[i] <= 1'b1;
                    end
                end else if (start_da[i] && sample_valid[i]) begin
                    hist[i][0] <= int'(sample_in[i]);
                    hist[i][1] <= hist[i][0];
                    hist[i][2] <= hist[i][1];
                    hist[i][3] <= hist[i][2];
                    pend[i] <= coef[i][0] * int'(sample_in[i]) + coef[i][1] * hist[i][0]
                             + coef[i][2] * hist[i][1] + coef[i][3] * hist[i][2];
                    rem[i] <= DW;
                end
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("y_valid[%0d]", i), int'(y_valid[i]), int'(yv_exp[i]));
                check($sformatf("sample_ready[%0d]", i), int'(sample_ready[i]),
                      int'(rem[i] == 0 && start_da[i] && !reset_da[i]));
                check($sformatf("y_out[%0d]", i), int'(y_out[i]), y_exp[i]);
            end
            if (y_valid[0] === 1'b1) begin
                res0.push_back(int'(y_out[0]));
                stamp0.push_back(cyc);
            end
            if (y_valid[1] === 1'b1) res1.push_back(int'(y_out[1]));
        end
    end

    // Holds the sample until the model reports it was taken, then drops valid.
    task automatic apply_stimulus(input int i, input int value);
        bit taken = 1'b0;
        sample_in[i]    = DW'(value);
        sample_valid[i] = 1'b1;
        for (int n = 0; n < 40 && !taken; n++) begin
            @(negedge clk);
            if (rem[i] == DW) taken = 1'b1;
        end
        if (!taken) check("accept_timeout", 0, 1);
        sample_valid[i] = 1'b0;
    endtask

    task automatic wait_results(input int i, input int n);
        int got = 0;
        for (int c = 0; c < 200; c++) begin
            got = (i == 0) ? res0.size() : res1.size();
            if (got >= n) break;
            @(negedge clk);
        end
        if (got < n) check("result_timeout", got, n);
    endtask

    initial begin
        int imp [5] = '{3, -5, 7, 2, 0};
        int stp [5] = '{300, -200, 500, 700, 700};
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            reset_da[i] = 1'b0; start_da[i] = 1'b0;
            sample_in[i] = '0;  sample_valid[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checking = 1'b1;
        @(negedge clk);
        #3;
        check("reset y_out", int'(y_out[0]), 0);
        check("reset y_valid", int'(y_valid[0]), 0);

        resetn = 1'b1;
        start_da[0] = 1'b1;
        reset_da[0] = 1'b1;
        @(negedge clk);
        #3;
        check("ready under reset_DA", int'(sample_ready[0]), 0);
        reset_da[0] = 1'b0;
        @(negedge clk);
        #3;
        check("ready after reset", int'(sample_ready[0]), 1);

        $display("[TB] impulse");
        res0.delete(); stamp0.delete();
        for (int n = 0; n < 5; n++) apply_stimulus(0, (n == 0) ? 1 : 0);
        wait_results(0, 5);
        for (int n = 0; n < 5 && n < res0.size(); n++) check($sformatf("impulse[%0d]", n), res0[n], imp[n]);
        for (int n = 1; n < 5 && n < stamp0.size(); n++)
            check($sformatf("impulse spacing[%0d]", n), stamp0[n] - stamp0[n-1], 9);

        $display("[TB] step");
        res0.delete();
        for (int n = 0; n < 5; n++) apply_stimulus(0, 100);
        wait_results(0, 5);
        for (int n = 0; n < 5 && n < res0.size(); n++) check($sformatf("step[%0d]", n), res0[n], stp[n]);

        $display("[TB] held valid");
        repeat (10) @(negedge clk);
        res0.delete();
        sample_in[0] = 8'sd5;
        sample_valid[0] = 1'b1;
        repeat (20) @(negedge clk);
        sample_valid[0] = 1'b0;
        repeat (15) @(negedge clk);
        check("held accepts", res0.size(), 3);
        if (res0.size() == 3) check("held last", res0[2], 225);

        $display("[TB] start low");
        res0.delete();
        start_da[0] = 1'b0;
        sample_valid[0] = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        check("ready start low", int'(sample_ready[0]), 0);
        sample_valid[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("start low accepts", res0.size(), 0);
        start_da[0] = 1'b1;

        for (int pass = 0; pass < 2; pass++) begin
            $display("[TB] mid-calc reset pass %0d", pass);
            res0.delete();
            apply_stimulus(0, 50);
            repeat (4) @(negedge clk);
            if (pass == 0) reset_da[0] = 1'b1; else resetn = 1'b0;
            @(negedge clk);
            reset_da[0] = 1'b0;
            resetn = 1'b1;
            repeat (12) @(negedge clk);
            check("aborted results", res0.size(), 0);
            check("aborted y_out", int'(y_out[0]), 0);
            apply_stimulus(0, 1);
            wait_results(0, 1);
            if (res0.size() > 0) check("post-reset impulse", res0[0], 3);
        end

        $display("[TB] start drop");
        reset_da[0] = 1'b1;
        @(negedge clk);
        reset_da[0] = 1'b0;
        res0.delete();
        apply_stimulus(0, 10);
        repeat (2) @(negedge clk);
        start_da[0] = 1'b0;
        wait_results(0, 1);
        if (res0.size() > 0) check("start drop result", res0[0], 30);
        repeat (3) @(negedge clk);
        #3;
        check("ready after drop", int'(sample_ready[0]), 0);

        $display("[TB] extremes");
        start_da[1] = 1'b1;
        res1.delete();
        for (int n = 0; n < 4; n++) apply_stimulus(1, -128);
        wait_results(1, 4);
        if (res1.size() >= 4) check("extreme max", res1[3], 65536);
        res1.delete();
        for (int n = 0; n < 4; n++) apply_stimulus(1, 127);
        wait_results(1, 4);
        if (res1.size() >= 4) check("extreme min", res1[3], -65024);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
